// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// controller state encoding and fixed result constants.
package muldiv_pkg;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int MULDIV_ITERS = 32;

    // Quotient reported when the divisor is zero
    localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_addsub.sv
// (WIDTH+1)-bit adder/subtractor shared by the Booth multiply step, the
// non-restoring divide step and the final remainder restore.
module muldiv_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           sub,
    output logic [WIDTH:0] sum
);

    assign sum = sub ? (x - y) : (x + y);

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed multiply (radix-2 Booth) and divide (non-restoring) unit
// with a fixed 33-cycle start/done handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t state, state_next;

    logic [CNT_W-1:0]        count;
    logic                    op_q;
    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] b_q;
    logic [WIDTH:0]          acc;
    logic [WIDTH-1:0]        mq;
    logic                    q_m1;

    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_mag;
    logic [WIDTH:0]   add_x;
    logic [WIDTH:0]   add_y;
    logic [WIDTH:0]   add_sum;
    logic             add_sub;
    logic [WIDTH:0]   booth_val;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? negate(v) : v;
    endfunction

    assign busy  = (state != S_IDLE);
    assign b_mag = magnitude(b_q);

    // Adder operand selection: Booth add/sub of A, divide step on the shifted
    // partial remainder, or (in FINISH) the remainder restore add.
    always_comb begin
        add_x   = acc;
        add_y   = {a_q[WIDTH-1], a_q};
        add_sub = 1'b0;
        if (op_q == OP_DIV) begin
            add_y = {1'b0, b_mag};
            if (state == S_RUN) begin
                add_x   = {acc[WIDTH-1:0], mq[WIDTH-1]};
                add_sub = ~acc[WIDTH];
            end
        end else begin
            add_sub = mq[0] & ~q_m1;
        end
    end

    muldiv_addsub #(.WIDTH(WIDTH)) u_addsub (
        .x   (add_x),
        .y   (add_y),
        .sub (add_sub),
        .sum (add_sum)
    );

    assign booth_val = (mq[0] ^ q_m1) ? add_sum : acc;
    assign rem_mag   = acc[WIDTH] ? add_sum[WIDTH-1:0] : acc[WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start) state_next = S_RUN;
            S_RUN:    if (count == '0) state_next = S_FINISH;
            S_FINISH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            count       <= '0;
            op_q        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            mq          <= '0;
            q_m1        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        a_q         <= a;
                        b_q         <= b;
                        count       <= CNT_W'(WIDTH - 1);
                        acc         <= '0;
                        q_m1        <= 1'b0;
                        mq          <= (op == OP_DIV) ? magnitude(a) : b;
                        div_by_zero <= 1'b0;
                    end
                end
                S_RUN: begin
                    count <= count - 1'b1;
                    if (op_q == OP_DIV) begin
                        acc <= add_sum;
                        mq  <= {mq[WIDTH-2:0], ~add_sum[WIDTH]};
                    end else begin
                        // Arithmetic right shift of {acc, mq, q_m1}
                        {acc, mq, q_m1} <= {booth_val[WIDTH], booth_val, mq};
                    end
                end
                S_FINISH: begin
                    done <= 1'b1;
                    if (op_q == OP_MUL) begin
                        result_hi <= acc[WIDTH-1:0];
                        result_lo <= mq;
                    end else if (b_q == '0) begin
                        result_hi   <= a_q;
                        result_lo   <= WIDTH'(DIV0_QUOTIENT);
                        div_by_zero <= 1'b1;
                    end else begin
                        // Quotient truncates toward zero; remainder follows the dividend sign
                        result_hi <= a_q[WIDTH-1] ? negate(rem_mag) : rem_mag;
                        result_lo <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? negate(mq) : mq;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed literal cases plus randomized
// traffic compared every cycle against a cycle-count/arithmetic reference.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clock;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo),
        .div_by_zero (div_by_zero)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish (got running, need finished)");
        $fatal(1, "timeout");
    end

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } res_t;

    // Reference arithmetic in 64-bit signed integers
    function automatic res_t ref_model(input logic o, input logic [31:0] x, input logic [31:0] y);
        res_t   r;
        longint sx, sy, p, q, m;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r.dbz = 1'b0;
        if (o == OP_MUL) begin
            p    = sx * sy;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (y == 32'd0) begin
            r.hi  = x;
            r.lo  = 32'hFFFF_FFFF;
            r.dbz = 1'b1;
        end else begin
            q    = sx / sy;
            m    = sx % sy;
            r.hi = m[31:0];
            r.lo = q[31:0];
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted start produces done MULDIV_ITERS+1 edges later
    int          m_cnt  = 0;
    res_t        m_pend;
    logic        m_done = 1'b0;
    logic        m_dbz  = 1'b0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    always @(posedge clock) begin
        if (clear) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_hi   <= m_pend.hi;
                    m_lo   <= m_pend.lo;
                    m_dbz  <= m_pend.dbz;
                end
            end else if (start) begin
                m_cnt  <= MULDIV_ITERS + 1;
                m_pend <= ref_model(op, a, b);
                m_dbz  <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy), 32'(m_cnt != 0));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_dbz", 32'(div_by_zero), 32'(m_dbz));
            check("cyc_hi", result_hi, m_hi);
            check("cyc_lo", result_lo, m_lo);
        end
    end

    // Called at a negedge with the unit idle
    task automatic do_op(input string nm, input logic o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el, input logic ed);
        int   n;
        res_t r;
        r = ref_model(o, x, y);
        check({nm, "_model_hi"}, r.hi, eh);
        check({nm, "_model_lo"}, r.lo, el);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clock);
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check({nm, "_latency"}, 32'(n), 32'd33);
        check({nm, "_hi"}, result_hi, eh);
        check({nm, "_lo"}, result_lo, el);
        check({nm, "_dbz"}, 32'(div_by_zero), 32'(ed));
        check({nm, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clock);
        check({nm, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3: begin
                v = 32'($urandom_range(0, 20));
                if ($urandom_range(0, 1) == 1) v = (~v) + 32'd1;
            end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int n;
        int dones;
        clear = 1'b1; start = 1'b0; op = OP_MUL; a = 32'd0; b = 32'd0;
        @(negedge clock);
        chk_en = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", result_hi, 32'd0);
        check("reset_lo", result_lo, 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);

        do_op("mul_7_m3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        do_op("mul_min_min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
        do_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        do_op("mul_2_3", OP_MUL, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

        // start pulses while busy are ignored
        start = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9;
        @(negedge clock);
        start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 45; k++) begin
            start = (k == 4 || k == 9 || k == 19 || k == 31) ? 1'b1 : 1'b0;
            @(negedge clock);
            if (done === 1'b1) dones++;
        end
        start = 1'b0;
        check("busy_start_ignored_dones", 32'(dones), 32'd1);
        check("busy_start_ignored_lo", result_lo, 32'd81);

        // start held high across done: second op accepted at the edge ending done
        start = 1'b1; op = OP_MUL; a = 32'd11; b = 32'd13;
        @(negedge clock);
        op = OP_DIV; a = 32'd100; b = 32'd7;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("b2b_first_latency", 32'(n), 32'd33);
        check("b2b_first_lo", result_lo, 32'd143);
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("b2b_second_latency", 32'(n), 32'd33);
        check("b2b_second_hi", result_hi, 32'd2);
        check("b2b_second_lo", result_lo, 32'd14);
        @(negedge clock);

        // clear mid-RUN aborts without done
        start = 1'b1; op = OP_MUL; a = 32'd1000; b = 32'd1000;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < 10; k++) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_hi", result_hi, 32'd0);
        check("abort_lo", result_lo, 32'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        do_op("after_abort", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);

        // Randomized traffic, checked cycle by cycle against the model
        for (int k = 0; k < 3000; k++) begin
            clear = ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0;
            start = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            op    = $urandom_range(0, 1) == 1 ? OP_DIV : OP_MUL;
            a     = pick();
            b     = pick();
            @(negedge clock);
        end
        clear = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 40; k++) @(negedge clock);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
